// File: rtl/hls_macc_ctrl.sv
// hls_macc_ctrl: assembles 10-word operand frames for hls_macc, runs one ap_ctrl_hs
// transaction and streams back out1..out3 plus ap_return as a 4-word frame.
module hls_macc_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              macc_start,
    input  logic              macc_done,
    output logic [DATA_W-1:0] macc_in1,
    output logic [DATA_W-1:0] macc_in2,
    output logic [DATA_W-1:0] macc_in3,
    output logic [DATA_W-1:0] macc_in4,
    output logic [DATA_W-1:0] macc_in5,
    output logic [DATA_W-1:0] macc_in6,
    output logic [DATA_W-1:0] macc_in7,
    output logic [DATA_W-1:0] macc_in8,
    output logic [DATA_W-1:0] macc_in9,
    output logic [DATA_W-1:0] macc_in10,
    input  logic [DATA_W-1:0] macc_out1,
    input  logic [DATA_W-1:0] macc_out2,
    input  logic [DATA_W-1:0] macc_out3,
    input  logic              macc_out1_vld,
    input  logic              macc_out2_vld,
    input  logic              macc_out3_vld,
    input  logic [DATA_W-1:0] macc_return,
    output logic              busy,
    output logic              err,
    output logic [15:0]       frames_done
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, UNLOAD = 2'd3;

    logic [1:0]        state;
    logic [3:0]        idx;
    logic [1:0]        res_idx;
    logic [2:0]        seen;
    logic [2:0]        vld;
    logic [DATA_W-1:0] opnd [10];
    logic [DATA_W-1:0] res [4];

    assign vld = {macc_out3_vld, macc_out2_vld, macc_out1_vld};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            res_idx     <= '0;
            seen        <= '0;
            macc_start  <= 1'b0;
            err         <= 1'b0;
            frames_done <= '0;
            for (int i = 0; i < 10; i++) opnd[i] <= '0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
        end else begin
            case (state)
                IDLE: state <= LOAD;
                LOAD: if (s_valid) begin
                    opnd[idx] <= s_data;
                    if (idx == 4'd9) begin
                        idx        <= '0;
                        macc_start <= 1'b1;
                        seen       <= '0;
                        state      <= RUN;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                RUN: begin
                    if (vld[0]) res[0] <= macc_out1;
                    if (vld[1]) res[1] <= macc_out2;
                    if (vld[2]) res[2] <= macc_out3;
                    seen <= seen | vld;
                    if (macc_done) begin
                        res[3]     <= macc_return;
                        macc_start <= 1'b0;
                        res_idx    <= '0;
                        state      <= UNLOAD;
                        // strobes arriving alongside done still count as seen
                        if (!(&(seen | vld))) err <= 1'b1;
                    end
                end
                UNLOAD: if (m_ready) begin
                    res_idx <= res_idx + 2'd1;
                    if (res_idx == 2'd3) begin
                        frames_done <= frames_done + 16'd1;
                        state       <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_ready   = state == LOAD;
    assign m_valid   = state == UNLOAD;
    assign m_last    = m_valid && res_idx == 2'd3;
    assign m_data    = res[res_idx];
    assign busy      = state == RUN || state == UNLOAD;
    assign macc_in1  = opnd[0];
    assign macc_in2  = opnd[1];
    assign macc_in3  = opnd[2];
    assign macc_in4  = opnd[3];
    assign macc_in5  = opnd[4];
    assign macc_in6  = opnd[5];
    assign macc_in7  = opnd[6];
    assign macc_in8  = opnd[7];
    assign macc_in9  = opnd[8];
    assign macc_in10 = opnd[9];
endmodule

// File: tb/tb_hls_macc_ctrl.sv
// tb_hls_macc_ctrl: directed bench with a stub hls_macc core (done in the 5th start cycle,
// out3 strobe coincident with done).
module tb_hls_macc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid, s_ready;
    logic [31:0] m_data;
    logic        m_valid, m_ready, m_last;
    logic        macc_start, macc_done;
    logic [31:0] ins [10];
    logic [31:0] o1, o2, o3, ret;
    logic        v1, v2, v3;
    logic        busy, err;
    logic [15:0] frames_done;
    logic [2:0]  scnt;
    logic        drop2, stray;
    int          cyc = 0, scyc = 0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    hls_macc_ctrl dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .macc_start(macc_start), .macc_done(macc_done),
        .macc_in1(ins[0]), .macc_in2(ins[1]), .macc_in3(ins[2]), .macc_in4(ins[3]),
        .macc_in5(ins[4]), .macc_in6(ins[5]), .macc_in7(ins[6]), .macc_in8(ins[7]),
        .macc_in9(ins[8]), .macc_in10(ins[9]),
        .macc_out1(o1), .macc_out2(o2), .macc_out3(o3),
        .macc_out1_vld(v1), .macc_out2_vld(v2), .macc_out3_vld(v3),
        .macc_return(ret), .busy(busy), .err(err), .frames_done(frames_done)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) scnt <= '0;
        else scnt <= (macc_start && !macc_done) ? scnt + 3'd1 : 3'd0;

    assign macc_done = (macc_start && scnt == 3'd4) || stray;
    assign v1 = (macc_start && scnt == 3'd0) || stray;
    assign v2 = macc_start && scnt == 3'd1 && !drop2;
    assign v3 = macc_start && scnt == 3'd4;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (macc_start) scyc <= scyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pop(input int stall, input logic [31:0] exp, input logic lst, input string tag);
        int n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_hold"}, m_data, exp);
            chk({tag, "_hold_sready"}, {31'd0, s_ready}, 32'd0);
            @(negedge clk);
        end
        chk(tag, m_data, exp);
        chk({tag, "_last"}, {31'd0, m_last}, {31'd0, lst});
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic frame(input logic [31:0] base, input int stall,
                         input logic [31:0] e0, e1, e2, e3);
        for (int i = 1; i <= 10; i++) push(base + i);
        for (int i = 0; i < 10; i++) chk($sformatf("macc_in%0d", i + 1), ins[i], base + i + 1);
        chk("run_start", {31'd0, macc_start}, 32'd1);
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_sready", {31'd0, s_ready}, 32'd0);
        pop(stall, e0, 1'b0, "w0");
        pop(stall, e1, 1'b0, "w1");
        pop(stall, e2, 1'b0, "w2");
        pop(stall, e3, 1'b1, "w3");
        chk("post_sready", {31'd0, s_ready}, 32'd1);
        chk("post_mvalid", {31'd0, m_valid}, 32'd0);
        chk("post_in_hold", ins[9], base + 10);
    endtask

    initial begin
        int t0, s0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        drop2 = 1'b0; stray = 1'b0;
        o1 = 32'h11; o2 = 32'h22; o3 = 32'h33; ret = 32'h44;
        repeat (3) @(negedge clk);
        chk("rst_sready", {31'd0, s_ready}, 32'd0);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_mlast", {31'd0, m_last}, 32'd0);
        chk("rst_start", {31'd0, macc_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mdata", m_data, 32'd0);
        chk("rst_in1", ins[0], 32'd0);
        chk("rst_frames", {16'd0, frames_done}, 32'd0);
        rst_n = 1'b1;
        chk("rel_sready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("rel1_sready", {31'd0, s_ready}, 32'd1);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_sready", {31'd0, s_ready}, 32'd1);
        chk("stray_mvalid", {31'd0, m_valid}, 32'd0);

        t0 = cyc; s0 = scyc;
        frame(32'd0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
        chk("frame_cycles", cyc - t0, 32'd19);
        chk("start_cycles", scyc - s0, 32'd5);
        chk("frames1", {16'd0, frames_done}, 32'd1);
        chk("err_clean", {31'd0, err}, 32'd0);

        o1 = 32'h55; o2 = 32'h66; o3 = 32'h77; ret = 32'h88;
        frame(32'd20, 3, 32'h55, 32'h66, 32'h77, 32'h88);
        chk("frames2", {16'd0, frames_done}, 32'd2);

        drop2 = 1'b1;
        o1 = 32'h91; o2 = 32'h92; o3 = 32'h93; ret = 32'h94;
        frame(32'd40, 0, 32'h91, 32'h66, 32'h93, 32'h94);
        drop2 = 1'b0;
        chk("err_set", {31'd0, err}, 32'd1);

        o1 = 32'hA1; o2 = 32'hA2; o3 = 32'hA3; ret = 32'hA4;
        frame(32'd60, 1, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("frames4", {16'd0, frames_done}, 32'd4);

        for (int i = 1; i <= 6; i++) push(32'd300 + i);
        chk("part_in6", ins[5], 32'd306);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in1", ins[0], 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_frames", {16'd0, frames_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        o1 = 32'hB1; o2 = 32'hB2; o3 = 32'hB3; ret = 32'hB4;
        frame(32'd400, 0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        chk("frames_after_rst", {16'd0, frames_done}, 32'd1);

        force dut.frames_done = 16'hFFFE;
        @(negedge clk);
        release dut.frames_done;
        @(negedge clk);
        chk("preload", {16'd0, frames_done}, 32'h0000FFFE);
        frame(32'd500, 0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        chk("wrap_ffff", {16'd0, frames_done}, 32'h0000FFFF);
        o1 = 32'hC1; o2 = 32'hC2; o3 = 32'hC3; ret = 32'hC4;
        frame(32'd520, 0, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        chk("wrap_0000", {16'd0, frames_done}, 32'h00000000);
        frame(32'd540, 2, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        chk("wrap_0001", {16'd0, frames_done}, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
